// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
   localparam int PC_W = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, flush and occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             full, do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && !empty;
   assign rdata  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // The producer's credit scheme must never push into a full buffer.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      (push && !flush) |-> (!full || do_pop));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited in-order reads,
// buffers {pc, instr} for decode and squashes stale responses on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN       = PC_W,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = $bits(fetch_entry_t);

   fetch_state_t    state, state_nx;
   logic [XLEN-1:0] pc, rsp_pc, pend_pc, tgt;
   logic            pend;
   logic [CW-1:0]   outstanding, drop_cnt, drop_cnt_nx, fifo_count;
   logic [CW:0]     inflight;
   logic            req_fire, rsp_fire, held, push, pop, fifo_empty;
   fetch_entry_t    wentry, head;
   logic [EW-1:0]   head_bits;

   assign tgt            = redirect_pc & ~XLEN'(3);
   assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = (state != BOOT) && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign held           = imem_req_valid && !imem_req_ready;
   // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
   assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
   assign push           = rsp_fire && (drop_cnt == '0) && !redirect_valid;
   assign pop            = out_valid && out_ready && !redirect_valid;
   assign wentry         = '{pc: rsp_pc, instr: imem_rsp_data};

   // A request held at redirect still fires to its old address and is squashed later.
   always_comb begin
      drop_cnt_nx = drop_cnt;
      if (redirect_valid) begin
         drop_cnt_nx = outstanding + CW'(req_fire) - CW'(rsp_fire);
      end else begin
         if (rsp_fire && drop_cnt != '0) drop_cnt_nx = drop_cnt_nx - CW'(1);
         if (req_fire && pend)           drop_cnt_nx = drop_cnt_nx + CW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         BOOT:    state_nx = RUN;
         RUN:     if (drop_cnt_nx != '0) state_nx = FLUSH;
         FLUSH:   if (drop_cnt_nx == '0) state_nx = RUN;
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         pend        <= 1'b0;
         pend_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_nx;
         drop_cnt    <= drop_cnt_nx;
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
         if (redirect_valid) begin
            rsp_pc <= tgt;
            if (held) begin
               pend    <= 1'b1;
               pend_pc <= tgt;
            end else begin
               pend <= 1'b0;
               pc   <= tgt;
            end
         end else begin
            if (push) rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
            if (req_fire) begin
               pend <= 1'b0;
               pc   <= pend ? pend_pc : pc + XLEN'(INSTR_BYTES);
            end
         end
      end
   end

   sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (redirect_valid),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head_bits),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head      = fetch_entry_t'(head_bits);
   assign out_valid = !fifo_empty;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
endmodule
